// File: rtl/muldiv_unit_pipe_if.sv
// Request/response bundle between the pipeline controller and the M-extension unit.
// master = issuing controller, slave = muldiv_unit_pipe.
interface muldiv_unit_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_unit_pipe.sv
// RV32M/RV64M multiply/divide unit at configurable XLEN: multi-cycle multiply,
// restoring divide (one bit per cycle) with early-out for divide special cases.
module muldiv_unit_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_unit_pipe_if.slave io
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;

  logic [2:0]        op_p0;
  logic [XLEN-1:0]   a_p0, b_p0;
  logic [XLEN-1:0]   rem_p1, quo_p1, dvs_p1;
  logic              neg_q_p1, neg_r_p1;
  logic [XLEN-1:0]   res_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept;
  logic              div_zero, div_ovf, div_special;
  logic [XLEN-1:0]   special_res;

  logic [2:0]               mop;
  logic [XLEN-1:0]          ma_raw, mb_raw;
  logic signed [2*XLEN-1:0] ma_w, mb_w, mprod;
  logic [XLEN-1:0]          mul_res;

  logic [XLEN:0]     shifted, diff;
  logic              take;
  logic [XLEN-1:0]   fix_res;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                 input logic            neg);
    return neg ? -v : v;
  endfunction

  assign accept = io.in_valid && io.in_ready;

  // Divide special cases are resolved from the raw request and skip the divider.
  always_comb begin
    div_zero    = io.in_op[2] && (io.in_b == '0);
    div_ovf     = io.in_op[2] && !io.in_op[0] && (io.in_a == MOST_NEG) && (io.in_b == '1);
    div_special = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = io.in_op[1] ? io.in_a : '1;
    else if (div_ovf)
      special_res = io.in_op[1] ? '0 : io.in_a;
  end

  // Multiplier reads the live request only when it must finish in the accept cycle.
  always_comb begin
    mop    = (state == S_IDLE) ? io.in_op : op_p0;
    ma_raw = (state == S_IDLE) ? io.in_a  : a_p0;
    mb_raw = (state == S_IDLE) ? io.in_b  : b_p0;
    if (mop == OP_MULH || mop == OP_MULHSU)
      ma_w = $signed({{XLEN{ma_raw[XLEN-1]}}, ma_raw});
    else
      ma_w = $signed({{XLEN{1'b0}}, ma_raw});
    if (mop == OP_MULH)
      mb_w = $signed({{XLEN{mb_raw[XLEN-1]}}, mb_raw});
    else
      mb_w = $signed({{XLEN{1'b0}}, mb_raw});
    mprod   = ma_w * mb_w;
    mul_res = (mop == OP_MUL) ? mprod[XLEN-1:0] : mprod[2*XLEN-1:XLEN];
  end

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_p1, quo_p1[XLEN-1]};
    diff    = shifted - {1'b0, dvs_p1};
    take    = !diff[XLEN];
    fix_res = op_p0[1] ? apply_sign(rem_p1, neg_r_p1) : apply_sign(quo_p1, neg_q_p1);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_p0;
    if (io.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            if (!io.in_op[2]) begin
              if (MUL_LAT == 1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_LAT - 2);
              end
            end else if (div_special) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
              cnt_d   = CNT_W'(XLEN - 1);
            end
          end
        end
        S_MUL: begin
          if (cnt_p0 == '0) state_d = S_DONE;
          else              cnt_d   = cnt_p0 - CNT_W'(1);
        end
        S_DIV: begin
          if (cnt_p0 == '0) state_d = S_FIX;
          else              cnt_d   = cnt_p0 - CNT_W'(1);
        end
        S_FIX:  state_d = S_DONE;
        S_DONE: if (io.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt_p0 <= '0;
    end else begin
      state  <= state_d;
      cnt_p0 <= cnt_d;
    end
  end

  // p0: request capture; p1: divider accumulators; result register feeds the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p0    <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      rem_p1   <= '0;
      quo_p1   <= '0;
      dvs_p1   <= '0;
      neg_q_p1 <= 1'b0;
      neg_r_p1 <= 1'b0;
      res_q    <= '0;
      tag_q    <= '0;
    end else begin
      if (accept) begin
        op_p0    <= io.in_op;
        a_p0     <= io.in_a;
        b_p0     <= io.in_b;
        tag_q    <= io.in_tag;
        rem_p1   <= '0;
        quo_p1   <= magnitude(io.in_a, !io.in_op[0]);
        dvs_p1   <= magnitude(io.in_b, !io.in_op[0]);
        neg_q_p1 <= !io.in_op[0] && (io.in_a[XLEN-1] ^ io.in_b[XLEN-1]);
        neg_r_p1 <= !io.in_op[0] && io.in_a[XLEN-1];
        if (div_special)
          res_q <= special_res;
        else if (!io.in_op[2] && (MUL_LAT == 1))
          res_q <= mul_res;
      end
      if (state == S_DIV && !io.flush) begin
        rem_p1 <= take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_p1 <= {quo_p1[XLEN-2:0], take};
      end
      if (state == S_MUL && cnt_p0 == '0 && !io.flush)
        res_q <= mul_res;
      if (state == S_FIX && !io.flush)
        res_q <= fix_res;
    end
  end

  assign io.in_ready   = (state == S_IDLE) && !io.flush;
  assign io.out_valid  = (state == S_DONE);
  assign io.out_result = res_q;
  assign io.out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit_pipe.sv
// Bench for muldiv_unit_pipe: 32-bit and 16-bit instances against an
// arithmetic reference model of the M-extension operations.
module tb_muldiv_unit_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  muldiv_unit_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  muldiv_unit_pipe_if #(.XLEN(16), .TAG_W(5)) b16 ();

  muldiv_unit_pipe #(.XLEN(32), .TAG_W(5), .MUL_LAT(2)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .io  (b32)
  );

  muldiv_unit_pipe #(.XLEN(16), .TAG_W(5), .MUL_LAT(2)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .io  (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain-arithmetic reference of the eight operations at width w (16 or 32).
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint          mask, half, ua, ub, sa, sb, r;
    longint unsigned pu;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'd0, a}) & mask;
    ub   = longint'({32'd0, b}) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: begin
        pu = unsigned'(ua) * unsigned'(ub);
        r  = longint'(pu >> w);
      end
      3'd4: r = (ub == 0) ? -1 : ((sa == -half && sb == -1) ? sa : sa / sb);
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : ((sa == -half && sb == -1) ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint mask, half, ua, ub;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'd0, a}) & mask;
    ub   = longint'({32'd0, b}) & mask;
    if (!op[2]) return 2;
    if (ub == 0) return 1;
    if (!op[0] && ua == half && ub == mask) return 1;
    return w + 2;
  endfunction

  // Issue one request with out_ready high; report latency, result and tag seen.
  task automatic do32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, output int lat,
                      output logic [31:0] res, output logic [4:0] otag);
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.in_op    = op;
    b32.in_a     = a;
    b32.in_b     = b;
    b32.in_tag   = tag;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      b32.in_valid = 1'b0;
    end while (b32.out_valid !== 1'b1 && lat < 200);
    res  = b32.out_result;
    otag = b32.out_tag;
  endtask

  task automatic do16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [4:0] tag, output int lat,
                      output logic [15:0] res, output logic [4:0] otag);
    @(negedge clk);
    b16.in_valid = 1'b1;
    b16.in_op    = op;
    b16.in_a     = a;
    b16.in_b     = b;
    b16.in_tag   = tag;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      b16.in_valid = 1'b0;
    end while (b16.out_valid !== 1'b1 && lat < 200);
    res  = b16.out_result;
    otag = b16.out_tag;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (b32.out_valid !== 1'b0 || b32.out_result !== 32'd0 || b32.out_tag !== 5'd0 || b32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset32: got valid=%b res=%h tag=%0d rdy=%b, want 0/0/0/1",
               b32.out_valid, b32.out_result, b32.out_tag, b32.in_ready);
    end
    n_cmp++;
    if (b16.out_valid !== 1'b0 || b16.out_result !== 16'd0 || b16.out_tag !== 5'd0) begin
      n_bad++;
      $display("FAIL reset16: got valid=%b res=%h tag=%0d, want 0/0/0",
               b16.out_valid, b16.out_result, b16.out_tag);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset: got valid=%b rdy=%b, want 0/1", b32.out_valid, b32.in_ready);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  t_op [4];
    logic [31:0] t_a [4];
    logic [31:0] t_b [4];
    logic [31:0] t_r [4];
    logic [31:0] res, a, b, exp;
    logic [4:0]  otag, tag;
    logic [2:0]  op;
    int          lat;
    t_op = '{3'd0, 3'd3, 3'd2, 3'd1};
    t_a  = '{32'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    t_b  = '{32'd10, 32'hFFFF_FFFF, 32'd1,         32'h8000_0000};
    t_r  = '{32'h96, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
    for (int i = 0; i < 4; i++) begin
      do32(t_op[i], t_a[i], t_b[i], 5'd17, lat, res, otag);
      n_cmp++;
      if (res !== t_r[i] || lat !== 2 || otag !== 5'd17) begin
        n_bad++;
        $display("FAIL mul_dir[%0d]: got res=%h lat=%0d tag=%0d, want res=%h lat=2 tag=17",
                 i, res, lat, otag, t_r[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      op  = 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      tag = 5'($urandom);
      exp = ref_model(32, op, a, b);
      do32(op, a, b, tag, lat, res, otag);
      n_cmp++;
      if (res !== exp || lat !== 2 || otag !== tag) begin
        n_bad++;
        $display("FAIL mul_rand op=%0d a=%h b=%h: got res=%h lat=%0d tag=%0d, want res=%h lat=2 tag=%0d",
                 op, a, b, res, lat, otag, exp, tag);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  t_op [5];
    logic [31:0] t_a [5];
    logic [31:0] t_b [5];
    logic [31:0] t_r [5];
    logic [31:0] res, a, b, exp;
    logic [4:0]  otag, tag;
    logic [2:0]  op;
    int          lat, elat;
    t_op = '{3'd4, 3'd6, 3'd4, 3'd7, 3'd5};
    t_a  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'h8000_0000};
    t_b  = '{32'd3,         32'd3,         32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFF};
    t_r  = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6,         32'd5,         32'd0};
    for (int i = 0; i < 5; i++) begin
      do32(t_op[i], t_a[i], t_b[i], 5'(i + 1), lat, res, otag);
      n_cmp++;
      if (res !== t_r[i] || lat !== 34 || otag !== 5'(i + 1)) begin
        n_bad++;
        $display("FAIL div_dir[%0d]: got res=%h lat=%0d tag=%0d, want res=%h lat=34 tag=%0d",
                 i, res, lat, otag, t_r[i], i + 1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      op  = 3'($urandom_range(4, 7));
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      tag = 5'($urandom);
      exp = ref_model(32, op, a, b);
      elat = ref_lat(32, op, a, b);
      do32(op, a, b, tag, lat, res, otag);
      n_cmp++;
      if (res !== exp || lat !== elat || otag !== tag) begin
        n_bad++;
        $display("FAIL div_rand op=%0d a=%h b=%h: got res=%h lat=%0d tag=%0d, want res=%h lat=%0d tag=%0d",
                 op, a, b, res, lat, otag, exp, elat, tag);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  t_op [6];
    logic [31:0] t_a [6];
    logic [31:0] t_b [6];
    logic [31:0] t_r [6];
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat;
    t_op = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    t_a  = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_r  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    for (int i = 0; i < 6; i++) begin
      do32(t_op[i], t_a[i], t_b[i], 5'(i + 20), lat, res, otag);
      n_cmp++;
      if (res !== t_r[i] || lat !== 1 || otag !== 5'(i + 20)) begin
        n_bad++;
        $display("FAIL special[%0d]: got res=%h lat=%0d tag=%0d, want res=%h lat=1 tag=%0d",
                 i, res, lat, otag, t_r[i], i + 20);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.in_op     = 3'd0;
    b32.in_a      = 32'd6;
    b32.in_b      = 32'd7;
    b32.in_tag    = 5'd9;
    @(negedge clk);
    b32.in_op  = 3'd0;
    b32.in_a   = 32'd1;
    b32.in_b   = 32'd1;
    b32.in_tag = 5'd1;
    n = 0;
    while (b32.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (b32.out_valid !== 1'b1 || b32.out_result !== 32'd42 || b32.out_tag !== 5'd9 || b32.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b res=%h tag=%0d rdy=%b, want 1/0000002a/9/0",
                 i, b32.out_valid, b32.out_result, b32.out_tag, b32.in_ready);
      end
      @(negedge clk);
    end
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b rdy=%b, want 0/1", b32.out_valid, b32.in_ready);
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (b32.out_valid === 1'b1) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL bp_dup: got %0d extra valid cycles, want 0", n);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat, seen;
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.in_op    = 3'd4;
    b32.in_a     = 32'd1000;
    b32.in_b     = 32'd7;
    b32.in_tag   = 5'd11;
    @(negedge clk);
    b32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    #1;
    n_cmp++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got rdy=%b valid=%b, want 1/0", b32.in_ready, b32.out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL flush_drop: got %0d valid cycles, want 0", seen);
    end
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.flush    = 1'b1;
    b32.in_op    = 3'd0;
    b32.in_a     = 32'd2;
    b32.in_b     = 32'd2;
    b32.in_tag   = 5'd4;
    #1;
    n_cmp++;
    if (b32.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_block_rdy: got rdy=%b, want 0", b32.in_ready);
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    b32.flush    = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b32.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL flush_block: got %0d valid cycles, want 0", seen);
    end
    do32(3'd0, 32'd3, 32'd4, 5'd12, lat, res, otag);
    n_cmp++;
    if (res !== 32'd12 || lat !== 2 || otag !== 5'd12) begin
      n_bad++;
      $display("FAIL flush_after: got res=%h lat=%0d tag=%0d, want res=0000000c lat=2 tag=12",
               res, lat, otag);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  otag;
    int          lat, seen;
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.in_op    = 3'd4;
    b32.in_a     = 32'd1000;
    b32.in_b     = 32'd7;
    b32.in_tag   = 5'd23;
    @(negedge clk);
    b32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (b32.out_valid !== 1'b0 || b32.out_result !== 32'd0 || b32.out_tag !== 5'd0 || b32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_rst: got valid=%b res=%h tag=%0d rdy=%b, want 0/0/0/1",
               b32.out_valid, b32.out_result, b32.out_tag, b32.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rst_drop: got %0d valid cycles, want 0", seen);
    end
    do32(3'd0, 32'd3, 32'd4, 5'd13, lat, res, otag);
    n_cmp++;
    if (res !== 32'd12 || lat !== 2 || otag !== 5'd13) begin
      n_bad++;
      $display("FAIL rst_after: got res=%h lat=%0d tag=%0d, want res=0000000c lat=2 tag=13",
               res, lat, otag);
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] res, a, b, exp;
    logic [4:0]  otag, tag;
    logic [2:0]  op;
    int          lat, elat;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      tag  = 5'($urandom);
      exp  = ref_model(32, op, a, b);
      elat = ref_lat(32, op, a, b);
      do32(op, a, b, tag, lat, res, otag);
      n_cmp++;
      if (res !== exp || lat !== elat || otag !== tag) begin
        n_bad++;
        $display("FAIL mix op=%0d a=%h b=%h: got res=%h lat=%0d tag=%0d, want res=%h lat=%0d tag=%0d",
                 op, a, b, res, lat, otag, exp, elat, tag);
      end
    end
  endtask

  task automatic test_xlen16();
    logic [2:0]  t_op [3];
    logic [15:0] t_a [3];
    logic [15:0] t_b [3];
    logic [15:0] t_r [3];
    int          t_l [3];
    logic [15:0] res, a, b;
    logic [31:0] exp;
    logic [4:0]  otag, tag;
    logic [2:0]  op;
    int          lat, elat;
    t_op = '{3'd1, 3'd5, 3'd6};
    t_a  = '{16'h8000, 16'hFFFE, 16'h8000};
    t_b  = '{16'h8000, 16'h0002, 16'hFFFF};
    t_r  = '{16'h4000, 16'h7FFF, 16'h0000};
    t_l  = '{2, 18, 1};
    for (int i = 0; i < 3; i++) begin
      do16(t_op[i], t_a[i], t_b[i], 5'(i + 5), lat, res, otag);
      n_cmp++;
      if (res !== t_r[i] || lat !== t_l[i] || otag !== 5'(i + 5)) begin
        n_bad++;
        $display("FAIL x16_dir[%0d]: got res=%h lat=%0d tag=%0d, want res=%h lat=%0d tag=%0d",
                 i, res, lat, otag, t_r[i], t_l[i], i + 5);
      end
    end
    for (int i = 0; i < 16; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = 16'($urandom);
      b    = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(16, 31));
      tag  = 5'($urandom);
      exp  = ref_model(16, op, {16'd0, a}, {16'd0, b});
      elat = ref_lat(16, op, {16'd0, a}, {16'd0, b});
      do16(op, a, b, tag, lat, res, otag);
      n_cmp++;
      if (res !== exp[15:0] || lat !== elat || otag !== tag) begin
        n_bad++;
        $display("FAIL x16_rand op=%0d a=%h b=%h: got res=%h lat=%0d tag=%0d, want res=%h lat=%0d tag=%0d",
                 op, a, b, res, lat, otag, exp[15:0], elat, tag);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    b32.in_valid = 1'b0; b32.in_op = 3'd0; b32.in_a = '0; b32.in_b = '0;
    b32.in_tag = '0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_op = 3'd0; b16.in_a = '0; b16.in_b = '0;
    b16.in_tag = '0; b16.flush = 1'b0; b16.out_ready = 1'b1;

    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random_mix();
    test_xlen16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
